// File: rtl/solver_drain_pkg.sv
// Shared types and widths for the solver drain path.
// Holds the FSM state encoding and the packed pixel bundle carried by the output FIFO.
package solver_drain_pkg;

    localparam int SOLVER_ID_W = 6;
    localparam int RAM_ADDR_W  = 10;
    localparam int PIXEL_W     = 8;
    localparam int INDEX_W     = 16;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_SOLVE = 2'd1,
        READ       = 2'd2,
        FLUSH      = 2'd3
    } drain_state_e;

    // One streamed word: iteration value, linear index, end-of-pass flag.
    typedef struct packed {
        logic [PIXEL_W-1:0] data;
        logic [INDEX_W-1:0] index;
        logic               last;
    } pixel_t;

    localparam int PIXEL_BITS = $bits(pixel_t);

endpackage

// File: rtl/solver_drain_fifo.sv
// stream_fifo2: 2-entry synchronous FIFO with push/pop, count, full and empty.
// Ports: clock, reset, push_i, pop_i, data_i -> data_o (head), count_o, full_o, empty_o.
module stream_fifo2 #(
    parameter int W = 25
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic [1:0]   count_o,
    output logic         full_o,
    output logic         empty_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_q;
    logic         rd_q;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    assign empty_o = (count_q == 2'd0);
    assign full_o  = (count_q == 2'd2);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= ~wr_q;
            end
            if (do_pop) begin
                rd_q <= ~rd_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    a_no_overflow : assert property (
        @(posedge clock) disable iff (reset)
        !(push_i && full_o && !pop_i)
    );

endmodule

// File: rtl/solver_drain.sv
// solver_drain: walks every solver result RAM after solve_done and streams it out.
// Ports: start/solve_done control, rd_solver_id/rd_addr/rd_data_in RAM port,
// out_valid/out_ready/out_data/out_index/out_last stream, busy and sticky drained.
module solver_drain
    import solver_drain_pkg::*;
#(
    parameter int NUM_SOLVERS = 1,
    parameter int WORDS       = 1024
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      solve_done,
    output logic [SOLVER_ID_W-1:0]    rd_solver_id,
    output logic [RAM_ADDR_W-1:0]     rd_addr,
    input  logic signed [PIXEL_W-1:0] rd_data_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [PIXEL_W-1:0] out_data,
    output logic [INDEX_W-1:0]        out_index,
    output logic                      out_last,
    output logic                      busy,
    output logic                      drained
);

    localparam logic [SOLVER_ID_W-1:0] LAST_ID   = SOLVER_ID_W'(NUM_SOLVERS - 1);
    localparam logic [RAM_ADDR_W-1:0]  LAST_ADDR = RAM_ADDR_W'(WORDS - 1);

    drain_state_e           state_q;
    logic [SOLVER_ID_W-1:0] ptr_id_q, ptr_id_d;
    logic [RAM_ADDR_W-1:0]  ptr_addr_q, ptr_addr_d;
    logic [SOLVER_ID_W-1:0] rd_id_q;
    logic [RAM_ADDR_W-1:0]  rd_addr_q;
    logic                   inflight_q;
    logic [INDEX_W-1:0]     pend_index_q;
    logic                   pend_last_q;
    logic                   busy_q;
    logic                   drained_q;

    logic                   issue;
    logic                   pop;
    logic                   ptr_at_end;
    logic [1:0]             fifo_count;
    logic [1:0]             occupancy;
    logic                   fifo_full;
    logic                   fifo_empty;
    pixel_t                 push_pix;
    pixel_t                 head_pix;

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    // A slot freed by this cycle's pop is credited immediately, which keeps
    // one word per cycle flowing through the 2-entry FIFO.
    assign occupancy  = fifo_count + {1'b0, inflight_q} - {1'b0, pop};
    assign issue      = (state_q == READ) && (occupancy < 2'd2);
    assign ptr_at_end = (ptr_id_q == LAST_ID) && (ptr_addr_q == LAST_ADDR);

    // The RAM samples the address on the issue edge; between issues the
    // last address is held.
    assign rd_solver_id = issue ? ptr_id_q : rd_id_q;
    assign rd_addr      = issue ? ptr_addr_q : rd_addr_q;

    always_comb begin
        ptr_id_d   = ptr_id_q;
        ptr_addr_d = ptr_addr_q + 1'b1;
        if (ptr_addr_q == LAST_ADDR) begin
            ptr_addr_d = '0;
            ptr_id_d   = ptr_id_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_id_q     <= '0;
            ptr_addr_q   <= '0;
            rd_id_q      <= '0;
            rd_addr_q    <= '0;
            inflight_q   <= 1'b0;
            pend_index_q <= '0;
            pend_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            drained_q    <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                rd_id_q      <= ptr_id_q;
                rd_addr_q    <= ptr_addr_q;
                pend_index_q <= {ptr_id_q, ptr_addr_q};
                pend_last_q  <= ptr_at_end;
                ptr_id_q     <= ptr_id_d;
                ptr_addr_q   <= ptr_addr_d;
            end
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= WAIT_SOLVE;
                        busy_q     <= 1'b1;
                        drained_q  <= 1'b0;
                        ptr_id_q   <= '0;
                        ptr_addr_q <= '0;
                    end
                end
                WAIT_SOLVE: begin
                    if (solve_done) begin
                        state_q <= READ;
                    end
                end
                READ: begin
                    if (issue && ptr_at_end) begin
                        state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (!inflight_q && fifo_empty) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        drained_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign push_pix.data  = rd_data_in;
    assign push_pix.index = pend_index_q;
    assign push_pix.last  = pend_last_q;

    stream_fifo2 #(
        .W(PIXEL_BITS)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (inflight_q),
        .pop_i   (pop),
        .data_i  (push_pix),
        .data_o  (head_pix),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_data  = head_pix.data;
    assign out_index = head_pix.index;
    assign out_last  = head_pix.last;
    assign busy      = busy_q;
    assign drained   = drained_q;

    a_credit : assert property (
        @(posedge clock) disable iff (reset)
        !(fifo_full && inflight_q && !pop)
    );

endmodule

// File: tb/tb_solver_drain.sv
// Randomized self-checking bench for solver_drain with two solver RAMs.
// RAM model preloaded with addr[7:0]^id; expected stream computed from word order.
module tb_solver_drain;

    localparam int NS    = 2;
    localparam int WW    = 1024;
    localparam int TOTAL = NS * WW;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        solve_done = 1'b0;
    logic [5:0]  rd_solver_id;
    logic [9:0]  rd_addr;
    logic [7:0]  rd_data_in = 8'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic [15:0] out_index;
    logic        out_last;
    logic        busy;
    logic        drained;

    int checks = 0;
    int errors = 0;

    solver_drain #(
        .NUM_SOLVERS(NS),
        .WORDS      (WW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .solve_done  (solve_done),
        .rd_solver_id(rd_solver_id),
        .rd_addr     (rd_addr),
        .rd_data_in  (rd_data_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_index   (out_index),
        .out_last    (out_last),
        .busy        (busy),
        .drained     (drained)
    );

    always #5 clock = ~clock;

    // Result RAM: registered read of the preloaded pattern.
    always @(posedge clock) begin
        rd_data_in <= rd_addr[7:0] ^ {2'b00, rd_solver_id};
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_data(input int k);
        int id;
        int a;
        id = k / WW;
        a  = k % WW;
        return 8'(a) ^ 8'(id);
    endfunction

    // Stream monitor: every transfer is compared against the k-th word of
    // the pass; a stalled head must not change.
    int   exp_k = 0;
    int   last_cnt = 0;
    int   pass_no = 0;
    int   seen_pass = 0;
    bit   mon_en = 1'b0;
    bit   stall_q = 1'b0;
    logic [25:0] stall_snap = '0;

    always @(negedge clock) begin
        if (pass_no != seen_pass) begin
            seen_pass = pass_no;
            exp_k     = 0;
            last_cnt  = 0;
        end
        if (mon_en) begin
            if (stall_q) begin
                chk("hold", {6'd0, out_valid, out_last, out_index, out_data},
                    {6'd0, stall_snap});
            end
            if (out_valid && out_ready) begin
                chk("data", {24'd0, out_data}, {24'd0, exp_data(exp_k)});
                chk("index", {16'd0, out_index}, 32'(exp_k));
                chk("last", {31'd0, out_last}, {31'd0, exp_k == TOTAL - 1});
                if (out_last) last_cnt++;
                exp_k++;
            end
            stall_q    = out_valid && !out_ready;
            stall_snap = {1'b1, out_last, out_index, out_data};
        end else begin
            stall_q = 1'b0;
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_id"}, {26'd0, rd_solver_id}, 32'd0);
        chk({tag, "_addr"}, {22'd0, rd_addr}, 32'd0);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_data"}, {24'd0, out_data}, 32'd0);
        chk({tag, "_index"}, {16'd0, out_index}, 32'd0);
        chk({tag, "_last"}, {31'd0, out_last}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_drained"}, {31'd0, drained}, 32'd0);
    endtask

    // Returns after the edge that samples start.
    task automatic pulse_start();
        @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    // Counts edges from the call until drained; cycle 0 is the edge on
    // which READ was entered.
    task automatic wait_drained(input int max_cyc, input bit rnd,
                                output int cyc, output int fv);
        cyc = 0;
        fv  = -1;
        out_ready = rnd ? ($urandom_range(9) < 3) : 1'b1;
        while (cyc < max_cyc) begin
            @(posedge clock);
            #1;
            cyc++;
            if (out_valid && fv < 0) fv = cyc;
            if (drained) break;
            out_ready = rnd ? ($urandom_range(9) < 3) : 1'b1;
        end
        if (!drained) chk("drain_timeout", {31'd0, drained}, 32'd1);
    endtask

    int cyc;
    int fv;
    int bad;
    logic [15:0] rd_hold;

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk_reset_vals("rst");
        reset = 1'b0;
        mon_en = 1'b1;

        // Full pass, ready always high.
        pass_no++;
        solve_done = 1'b1;
        out_ready  = 1'b1;
        pulse_start();
        chk("busy_start", {31'd0, busy}, 32'd1);
        @(posedge clock);
        #1;
        wait_drained(5000, 1'b0, cyc, fv);
        chk("first_valid", 32'(fv), 32'd2);
        chk("drain_cyc", 32'(cyc), 32'(TOTAL + 3));
        chk("p1_words", 32'(exp_k), 32'(TOTAL));
        chk("p1_lasts", 32'(last_cnt), 32'd1);
        chk("p1_busy", {31'd0, busy}, 32'd0);

        // Random backpressure.
        pass_no++;
        pulse_start();
        chk("p2_drained_clr", {31'd0, drained}, 32'd0);
        wait_drained(30000, 1'b1, cyc, fv);
        chk("p2_words", 32'(exp_k), 32'(TOTAL));
        chk("p2_lasts", 32'(last_cnt), 32'd1);

        // solve_done held low for 50 cycles.
        pass_no++;
        solve_done = 1'b0;
        out_ready  = 1'b1;
        rd_hold    = {rd_solver_id, rd_addr};
        pulse_start();
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clock);
            #1;
            if (out_valid || !busy || {rd_solver_id, rd_addr} != rd_hold) bad++;
        end
        chk("wait_quiet", 32'(bad), 32'd0);
        solve_done = 1'b1;
        @(posedge clock);
        #1;
        wait_drained(5000, 1'b0, cyc, fv);
        chk("p3_first_valid", 32'(fv), 32'd2);
        chk("p3_words", 32'(exp_k), 32'(TOTAL));

        // Reset after 300 words, then a clean pass.
        pass_no++;
        pulse_start();
        for (int i = 0; i < 1000 && exp_k < 300; i++) begin
            @(posedge clock);
            #1;
        end
        chk("p4_reach300", {31'd0, exp_k >= 300}, 32'd1);
        mon_en = 1'b0;
        reset  = 1'b1;
        @(posedge clock);
        #1;
        chk_reset_vals("midrst");
        reset = 1'b0;
        pass_no++;
        mon_en = 1'b1;
        pulse_start();
        wait_drained(5000, 1'b0, cyc, fv);
        chk("p4_words", 32'(exp_k), 32'(TOTAL));
        chk("p4_lasts", 32'(last_cnt), 32'd1);

        // Second start mid-pass is ignored.
        pass_no++;
        pulse_start();
        for (int i = 0; i < 1000 && exp_k < 100; i++) begin
            @(posedge clock);
            #1;
        end
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        wait_drained(5000, 1'b0, cyc, fv);
        chk("p5_words", 32'(exp_k), 32'(TOTAL));
        chk("p5_lasts", 32'(last_cnt), 32'd1);

        // Permanent stall: only two reads may be outstanding.
        pass_no++;
        out_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 20 && !out_valid; i++) begin
            @(posedge clock);
            #1;
        end
        chk("p6_valid", {31'd0, out_valid}, 32'd1);
        repeat (20) @(posedge clock);
        #1;
        chk("p6_rd_addr", {22'd0, rd_addr}, 32'd1);
        chk("p6_rd_id", {26'd0, rd_solver_id}, 32'd0);
        chk("p6_head", {16'd0, out_index}, 32'd0);
        chk("p6_accepted", 32'(exp_k), 32'd0);
        chk("p6_busy", {31'd0, busy}, 32'd1);

        mon_en = 1'b0;
        reset  = 1'b1;
        @(posedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/solver_drain.md
Name: solver_drain

Overview:
- Reader-side companion to the multi-solver: once every pattern solver has finished, it walks each per-solver 1024x8 result RAM and streams the contents out.
- Drives the solver-id/address read port of the multi-solver and absorbs its 1-cycle RAM read latency.
- Presents a valid/ready pixel stream (iteration count plus linear index) to the downstream framebuffer writer, with full backpressure support.

Parameters:
- NUM_SOLVERS, 1, number of solver RAMs to drain (1..64).
- WORDS, 1024, words per solver RAM; addresses 0..WORDS-1.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle request to begin a drain pass.
- solve_done  in  1  multi-solver done (all solvers finished), level.
- rd_solver_id  out  6  RAM bank select to multi-solver.
- rd_addr  out  10  RAM word address to multi-solver.
- rd_data_in  in  8  signed RAM read data; valid 1 cycle after id/addr are presented.
- out_valid  out  1  stream data valid.
- out_ready  in  1  downstream accept.
- out_data  out  8  signed iteration value.
- out_index  out  16  {solver_id[5:0], addr[9:0]}.
- out_last  out  1  high with the final word (id NUM_SOLVERS-1, addr WORDS-1).
- busy  out  1  high from accepted start until the last word is accepted.
- drained  out  1  sticky; set when a pass completes, cleared by the next start or reset.

Behaviour:
- Reset values: rd_solver_id=0, rd_addr=0, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, drained=0. FSM resets to IDLE; FIFO resets empty; in-flight flag resets to 0.
- IDLE state:
  - start=1 -> WAIT_SOLVE; busy<=1; drained<=0; read pointer <= (0,0).
  - start while busy is ignored.
- WAIT_SOLVE state:
  - Holds until solve_done=1, then -> READ.
  - solve_done sampled low is not an error; the block waits indefinitely.
- READ state:
  - Issues one read per cycle when (fifo_count + inflight) < 2.
  - Issuing a read means: drive rd_solver_id/rd_addr with the pointer, set inflight for the next cycle, and advance the pointer.
  - The pointer increments addr; at WORDS-1 it wraps to 0 and increments solver_id.
  - After issuing (NUM_SOLVERS-1, WORDS-1), the FSM goes to FLUSH.
  - rd_solver_id/rd_addr hold their last value when no read is issued. The RAM updates its output only when selected, so rd_data_in stays stable.
- Read latency: the cycle after an issue, rd_data_in is pushed into a 2-entry output FIFO. The entry's index and last flag are registered alongside the issue.
- Output stream:
  - out_valid = FIFO non-empty. out_data/out_index/out_last come from the FIFO head.
  - A transfer occurs when out_valid & out_ready.
  - Head fields are stable while out_valid=1 and out_ready=0.
  - Push and pop in the same cycle leave the count unchanged.
  - The credit rule guarantees the FIFO never overflows. Overflow is a design error (assertion).
- FLUSH state: waits until inflight=0 and the FIFO is empty, then -> IDLE with busy<=0 and drained<=1 in the same cycle. This is the cycle after the out_last transfer.
- Throughput: with out_ready held high, one word per cycle.
  - First out_valid appears 2 cycles after entering READ.
  - A full pass takes NUM_SOLVERS*WORDS + 3 cycles from solve_done.
- Reset mid-pass: everything returns to reset values on the next edge. The partial stream is abandoned and no out_last is produced.
- start and reset in the same cycle: reset wins.
- NUM_SOLVERS=1: solver id stays 0 and out_index[15:10]=0.

Decomposition:
- Shared package:
  - SOLVER_ID_W=6, RAM_ADDR_W=10, PIXEL_W=8, INDEX_W=16.
  - FSM state encoding: IDLE, WAIT_SOLVE, READ, FLUSH.
- One sub-module: stream_fifo2, a 2-entry, 25-bit (data+index+last) synchronous FIFO with count, push/pop, full/empty. It is reusable by the framebuffer writer.

Test Plan:
- NUM_SOLVERS=2, RAM model preloaded with data=addr[7:0]^id; start, solve_done=1, out_ready=1.
  -> 2048 transfers in order, index 0..2047, data matching the preload.
  -> out_last only on index 2047; drained=1 at cycle 2051.
- Random out_ready (about 30% high).
  -> Identical ordered stream, no duplicates or drops.
  -> Head stable while stalled; FIFO count never exceeds 2.
- start with solve_done=0 for 50 cycles, then raised.
  -> No rd_addr activity and no out_valid while waiting; busy=1 throughout.
  -> First out_valid 2 cycles after solve_done rises.
- Reset asserted after 300 words, then start again.
  -> All outputs return to reset values.
  -> New pass restarts at index 0 and completes normally.
- start pulsed again mid-pass at word 100.
  -> Ignored; the stream is unaffected and a single out_last is produced.
- out_ready=0 permanently after first valid.
  -> At most 2 reads are issued beyond the last accepted word, and rd_addr holds.
